// File: rtl/memory_access_stage_pkg.sv
// Shared pipeline definitions for the MEM stage: control bit positions,
// data-memory port FSM encodings and the MEM/WB bubble value.
package memory_access_stage_pkg;

    localparam int WB_REG_WRITE  = 1;
    localparam int WB_MEM_TO_REG = 0;
    localparam int MA_MEM_READ   = 1;
    localparam int MA_MEM_WRITE  = 0;

    localparam logic BUBBLE_REG_WRITE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } memState_t;

    function automatic logic isAccess(input logic [1:0] maCtl);
        return maCtl[MA_MEM_READ] | maCtl[MA_MEM_WRITE];
    endfunction

endpackage

// File: rtl/memory_access_stage_dmem_port_ctrl.sv
// Data-memory req/ack port: access FSM, timeout counter, request latches,
// read-data capture and the sticky bus-error flag.
module dmem_port_ctrl
    import memory_access_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  start,
    input  logic                  isWrite,
    input  logic [ADDR_WIDTH-1:0] addrIn,
    input  logic [DATA_WIDTH-1:0] wdataIn,
    input  logic [DATA_WIDTH-1:0] memRdata,
    input  logic                  memAck,
    output logic                  memReq,
    output logic                  memWe,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0] memWdata,
    output memState_t             state,
    output logic [DATA_WIDTH-1:0] readData,
    output logic                  busError
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);

    memState_t             stateR, stateNext;
    logic [CW-1:0]         cntR, cntNext, cntInc;
    logic                  reqNext, weNext, errNext;
    logic [ADDR_WIDTH-1:0] addrNext;
    logic [DATA_WIDTH-1:0] wdataNext, rdataNext;

    assign state  = stateR;
    assign cntInc = cntR + CNT_ONE;

    // Next-state and next-register values for the port FSM
    always_comb begin
        stateNext = stateR;
        cntNext   = cntR;
        reqNext   = memReq;
        weNext    = memWe;
        addrNext  = memAddr;
        wdataNext = memWdata;
        rdataNext = readData;
        errNext   = busError;
        case (stateR)
            ST_IDLE: begin
                if (start) begin
                    stateNext = ST_ACCESS;
                    cntNext   = CNT_ZERO;
                    reqNext   = 1'b1;
                    weNext    = isWrite;
                    addrNext  = addrIn;
                    wdataNext = wdataIn;
                end else begin
                    stateNext = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                cntNext = cntInc;
                // Ack takes priority over a timeout landing on the same edge
                if (memAck) begin
                    rdataNext = memRdata;
                    reqNext   = 1'b0;
                    stateNext = ST_DONE;
                end else if (cntInc >= CNT_LIMIT) begin
                    rdataNext = {DATA_WIDTH{1'b0}};
                    reqNext   = 1'b0;
                    errNext   = 1'b1;
                    stateNext = ST_DONE;
                end else begin
                    stateNext = ST_ACCESS;
                end
            end
            ST_DONE: begin
                cntNext   = CNT_ZERO;
                stateNext = ST_IDLE;
            end
            default: begin
                cntNext   = CNT_ZERO;
                reqNext   = 1'b0;
                stateNext = ST_IDLE;
            end
        endcase
    end

    // Port state and request latches, updated on the pipeline's falling edge
    always_ff @(negedge clk or negedge rstN) begin
        if (!rstN) begin
            stateR   <= ST_IDLE;
            cntR     <= CNT_ZERO;
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= {ADDR_WIDTH{1'b0}};
            memWdata <= {DATA_WIDTH{1'b0}};
            readData <= {DATA_WIDTH{1'b0}};
            busError <= 1'b0;
        end else begin
            stateR   <= stateNext;
            cntR     <= cntNext;
            memReq   <= reqNext;
            memWe    <= weNext;
            memAddr  <= addrNext;
            memWdata <= wdataNext;
            readData <= rdataNext;
            busError <= errNext;
        end
    end

endmodule

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: issues loads/stores through dmem_port_ctrl, stalls
// upstream while an access is outstanding and drives the MEM/WB register.
module memory_access_stage
    import memory_access_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic [1:0]            writeBackControlIn,
    input  logic [1:0]            memAccessControlIn,
    input  logic [DATA_WIDTH-1:0] result,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic [4:0]            rdIn,
    output logic                  memReq,
    output logic                  memWe,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0] memWdata,
    input  logic [DATA_WIDTH-1:0] memRdata,
    input  logic                  memAck,
    output logic                  stall,
    output logic                  memWbRegWrite,
    output logic [4:0]            memWbRd,
    output logic [DATA_WIDTH-1:0] memWbData,
    output logic                  busError
);

    logic                  access;
    memState_t             portState;
    logic [DATA_WIDTH-1:0] readData;

    logic                  regWriteR, regWriteNext;
    logic                  memToRegR, memToRegNext;
    logic [4:0]            rdR, rdNext;
    logic [DATA_WIDTH-1:0] resultR, resultNext;
    logic                  wbRegWriteNext;
    logic [4:0]            wbRdNext;
    logic [DATA_WIDTH-1:0] wbDataNext;

    assign access = isAccess(memAccessControlIn);

    // Gated by rstN so upstream is released the moment reset asserts
    assign stall = rstN & (((portState == ST_IDLE) & access) | (portState == ST_ACCESS));

    dmem_port_ctrl #(
        .DATA_WIDTH     (DATA_WIDTH),
        .ADDR_WIDTH     (ADDR_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) uPort (
        .clk      (clk),
        .rstN     (rstN),
        .start    (access),
        .isWrite  (memAccessControlIn[MA_MEM_WRITE]),
        .addrIn   (result[ADDR_WIDTH-1:0]),
        .wdataIn  (writeData),
        .memRdata (memRdata),
        .memAck   (memAck),
        .memReq   (memReq),
        .memWe    (memWe),
        .memAddr  (memAddr),
        .memWdata (memWdata),
        .state    (portState),
        .readData (readData),
        .busError (busError)
    );

    // Instruction latches and MEM/WB next values, including the writeback mux
    always_comb begin
        regWriteNext   = regWriteR;
        memToRegNext   = memToRegR;
        rdNext         = rdR;
        resultNext     = resultR;
        wbRegWriteNext = memWbRegWrite;
        wbRdNext       = memWbRd;
        wbDataNext     = memWbData;
        case (portState)
            ST_IDLE: begin
                if (access) begin
                    regWriteNext   = writeBackControlIn[WB_REG_WRITE];
                    memToRegNext   = writeBackControlIn[WB_MEM_TO_REG];
                    rdNext         = rdIn;
                    resultNext     = result;
                    wbRegWriteNext = BUBBLE_REG_WRITE;
                end else begin
                    wbRegWriteNext = writeBackControlIn[WB_REG_WRITE];
                    wbRdNext       = rdIn;
                    wbDataNext     = result;
                end
            end
            ST_ACCESS: begin
                wbRegWriteNext = BUBBLE_REG_WRITE;
            end
            ST_DONE: begin
                wbRegWriteNext = regWriteR;
                wbRdNext       = rdR;
                wbDataNext     = memToRegR ? readData : resultR;
            end
            default: begin
                wbRegWriteNext = BUBBLE_REG_WRITE;
            end
        endcase
    end

    // MEM/WB register and latched instruction fields
    always_ff @(negedge clk or negedge rstN) begin
        if (!rstN) begin
            regWriteR     <= 1'b0;
            memToRegR     <= 1'b0;
            rdR           <= 5'd0;
            resultR       <= {DATA_WIDTH{1'b0}};
            memWbRegWrite <= 1'b0;
            memWbRd       <= 5'd0;
            memWbData     <= {DATA_WIDTH{1'b0}};
        end else begin
            regWriteR     <= regWriteNext;
            memToRegR     <= memToRegNext;
            rdR           <= rdNext;
            resultR       <= resultNext;
            memWbRegWrite <= wbRegWriteNext;
            memWbRd       <= wbRdNext;
            memWbData     <= wbDataNext;
        end
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// Table-driven bench for memory_access_stage with a writeback scoreboard
// and hand-written reset-during-access sequence.
module tb_memory_access_stage;
    import memory_access_stage_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 16;

    logic          clk = 1'b1;
    logic          rstN;
    logic [1:0]    wbCtl, maCtl;
    logic [DW-1:0] result, writeData, memRdata;
    logic [4:0]    rdIn;
    logic          memAck;
    logic          memReq, memWe, stall, memWbRegWrite, busError;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memWdata, memWbData;
    logic [4:0]    memWbRd;

    always #5 clk = ~clk;

    memory_access_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk                (clk),
        .rstN               (rstN),
        .writeBackControlIn (wbCtl),
        .memAccessControlIn (maCtl),
        .result             (result),
        .writeData          (writeData),
        .rdIn               (rdIn),
        .memReq             (memReq),
        .memWe              (memWe),
        .memAddr            (memAddr),
        .memWdata           (memWdata),
        .memRdata           (memRdata),
        .memAck             (memAck),
        .stall              (stall),
        .memWbRegWrite      (memWbRegWrite),
        .memWbRd            (memWbRd),
        .memWbData          (memWbData),
        .busError           (busError)
    );

    typedef struct {
        logic [1:0]  wb;
        logic [1:0]  ma;
        logic [31:0] res;
        logic [31:0] wd;
        logic [31:0] rdata;
        logic [4:0]  rd;
        int          ackDelay;   // ack on this ACCESS edge; 0 = never ack
        logic        expRegWrite;
        logic [4:0]  expRd;
        logic [31:0] expData;
        logic        expBusErr;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    vec_t vecs [12];
    wb_t  sbq [$];
    wb_t  sbExp;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic runVec(input vec_t v, input int idx);
        logic acc;
        int   nEdges, stallCnt, reqCnt;
        acc    = v.ma[1] | v.ma[0];
        nEdges = (acc == 1'b0) ? 1 : ((v.ackDelay > 0) ? v.ackDelay + 2 : TO + 2);
        wbCtl = v.wb; maCtl = v.ma; result = v.res; writeData = v.wd;
        memRdata = v.rdata; rdIn = v.rd;
        if (v.expRegWrite) sbq.push_back('{v.expRd, v.expData});
        stallCnt = 0;
        reqCnt   = 0;
        for (int e = 1; e <= nEdges; e++) begin
            // ack is asserted throughout a non-memory op to show it is ignored
            memAck = (acc == 1'b0) || ((v.ackDelay > 0) && (e == v.ackDelay + 1));
            #1;
            if (stall) stallCnt++;
            tick();
            if (memReq) reqCnt++;
            if (acc && e == 1) begin
                chk($sformatf("v%0d_memWe", idx), 32'(memWe), 32'(v.ma[0]));
                chk($sformatf("v%0d_memAddr", idx), memAddr, v.res);
                if (v.ma[0]) chk($sformatf("v%0d_memWdata", idx), memWdata, v.wd);
            end
        end
        memAck = 1'b0;
        wbCtl = 2'b00; maCtl = 2'b00;
        chk($sformatf("v%0d_stallEdges", idx), 32'(stallCnt), acc ? 32'(nEdges - 1) : 32'd0);
        chk($sformatf("v%0d_reqEdges", idx), 32'(reqCnt), acc ? 32'(nEdges - 2) : 32'd0);
        chk($sformatf("v%0d_regWrite", idx), 32'(memWbRegWrite), 32'(v.expRegWrite));
        chk($sformatf("v%0d_rd", idx), 32'(memWbRd), 32'(v.expRd));
        chk($sformatf("v%0d_data", idx), memWbData, v.expData);
        chk($sformatf("v%0d_busError", idx), 32'(busError), 32'(v.expBusErr));
    endtask

    initial begin
        //           wb     ma     res           wd        rdata         rd     ack rw    rd     data          err
        vecs[0]  = '{2'b10, 2'b00, 32'h00001234, 32'h0, 32'h0,        5'd5,  0,  1'b1, 5'd5,  32'h00001234, 1'b0};
        vecs[1]  = '{2'b11, 2'b10, 32'h00000040, 32'h0, 32'hCAFEF00D, 5'd7,  2,  1'b1, 5'd7,  32'hCAFEF00D, 1'b0};
        vecs[2]  = '{2'b10, 2'b00, 32'h0000ABCD, 32'h0, 32'h0,        5'd8,  0,  1'b1, 5'd8,  32'h0000ABCD, 1'b0};
        vecs[3]  = '{2'b00, 2'b01, 32'h00000080, 32'h55, 32'h0,       5'd3,  1,  1'b0, 5'd3,  32'h00000080, 1'b0};
        vecs[4]  = '{2'b00, 2'b00, 32'h00000077, 32'h0, 32'h0,        5'd4,  0,  1'b0, 5'd4,  32'h00000077, 1'b0};
        vecs[5]  = '{2'b10, 2'b10, 32'h00000100, 32'h0, 32'hDEADBEEF, 5'd9,  3,  1'b1, 5'd9,  32'h00000100, 1'b0};
        vecs[6]  = '{2'b00, 2'b11, 32'h000000C0, 32'h99, 32'h0,       5'd2,  1,  1'b0, 5'd2,  32'h000000C0, 1'b0};
        vecs[7]  = '{2'b11, 2'b10, 32'h00000044, 32'h0, 32'h00001357, 5'd10, 16, 1'b1, 5'd10, 32'h00001357, 1'b0};
        vecs[8]  = '{2'b11, 2'b10, 32'h00000048, 32'h0, 32'h0000FFFF, 5'd11, 0,  1'b1, 5'd11, 32'h00000000, 1'b1};
        vecs[9]  = '{2'b10, 2'b00, 32'h0000005A, 32'h0, 32'h0,        5'd12, 0,  1'b1, 5'd12, 32'h0000005A, 1'b1};
        vecs[10] = '{2'b10, 2'b00, 32'h00000066, 32'h0, 32'h0,        5'd13, 0,  1'b1, 5'd13, 32'h00000066, 1'b0};
        vecs[11] = '{2'b11, 2'b10, 32'h00000050, 32'h0, 32'h00002468, 5'd14, 1,  1'b1, 5'd14, 32'h00002468, 1'b0};

        rstN = 1'b0; wbCtl = 2'b00; maCtl = 2'b00; result = 32'h0; writeData = 32'h0;
        memRdata = 32'h0; rdIn = 5'd0; memAck = 1'b0;

        // Scoreboard: every MEM/WB load with regWrite=1 must match the oldest expectation
        fork
            forever begin
                @(posedge clk);
                if (rstN && memWbRegWrite) begin
                    if (sbq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_unexpected: writeback rd=%0d data=%h with nothing expected", memWbRd, memWbData);
                    end else begin
                        sbExp = sbq.pop_front();
                        chk("sb_rd", 32'(memWbRd), 32'(sbExp.rd));
                        chk("sb_data", memWbData, sbExp.data);
                    end
                end
            end
        join_none

        #12;
        chk("rst_memReq", 32'(memReq), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_regWrite", 32'(memWbRegWrite), 32'd0);
        chk("rst_data", memWbData, 32'd0);
        chk("rst_busError", 32'(busError), 32'd0);
        @(posedge clk);
        #2 rstN = 1'b1;
        #1;

        for (int i = 0; i < 10; i++) runVec(vecs[i], i);

        // Reset asserted while a load is waiting for its ack
        wbCtl = 2'b11; maCtl = 2'b10; result = 32'h60; rdIn = 5'd15; memAck = 1'b0;
        tick();
        tick();
        chk("rstmid_reqBefore", 32'(memReq), 32'd1);
        #1 rstN = 1'b0;
        #1;
        chk("rstmid_memReq", 32'(memReq), 32'd0);
        chk("rstmid_stall", 32'(stall), 32'd0);
        chk("rstmid_regWrite", 32'(memWbRegWrite), 32'd0);
        chk("rstmid_rd", 32'(memWbRd), 32'd0);
        chk("rstmid_data", memWbData, 32'd0);
        chk("rstmid_busError", 32'(busError), 32'd0);
        wbCtl = 2'b00; maCtl = 2'b00;
        @(posedge clk);
        #2 rstN = 1'b1;
        #1;

        for (int i = 10; i < 12; i++) runVec(vecs[i], i);

        tick();
        tick();
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
